// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the fp_addsub_arbiter block.
//   state_e       : request/execute/response sequencing states
//   OP_ADD/OP_SUB : encoding of the operation select bit
//   DEFAULT_*     : default datapath geometry
package fp_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned DEFAULT_CNT_W   = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at last_id+1 upward with modulo wrap and grants the
// first set bit.
//   req       in  : request vector
//   last_id   in  : index of the most recent winner (lowest priority now)
//   grant     out : one-hot grant, zero when no request is set
//   grant_id  out : binary index of the granted requester
//   any_grant out : at least one request is set
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_w;
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = 0;
    idx_w     = '0;
    // k runs 1..NUM_REQ so last_id itself is examined last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(last_id) + k) % NUM_REQ;
      idx_w = idx[ID_W-1:0];
      if (!any_grant && req[idx_w]) begin
        grant[idx_w] = 1'b1;
        grant_id     = idx_w;
        any_grant    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one external combinational add/subtract datapath among NUM_REQ
// requesters. A round-robin arbiter accepts one request per idle cycle,
// registers its operands toward the datapath, captures the result one cycle
// later and returns it with the requester ID on a valid/ready channel.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_op    : packed per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   fp_a/fp_b/fp_op       : registered operands to the shared datapath
//   fp_result             : combinational result from the shared datapath
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id/rsp_result     : owner ID and captured result
//   busy                  : not idle
//   op_count              : completed responses, wrapping
module fp_addsub_arbiter
  import fp_addsub_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_op,
  output logic [WIDTH-1:0]         fp_a,
  output logic [WIDTH-1:0]         fp_b,
  output logic                     fp_op,
  input  logic [WIDTH-1:0]         fp_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_id_q;
  logic [ID_W-1:0]    tag_q;
  logic [WIDTH-1:0]   fp_a_q, fp_b_q;
  logic               fp_op_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic [CNT_W-1:0]   op_count_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               any_grant;
  logic               accept;
  logic               rsp_fire;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               sel_op;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .last_id   (last_id_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  // Operand mux for the current winner.
  always_comb begin
    sel_a  = req_a[int'(grant_id) * WIDTH +: WIDTH];
    sel_b  = req_b[int'(grant_id) * WIDTH +: WIDTH];
    sel_op = req_op[grant_id];
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Ready is offered only to the winner, so a grant is a handshake.
        // Gated by rst_n so every output reads zero while reset is held.
        if (any_grant && rst_n) begin
          req_ready = grant;
          accept    = 1'b1;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_id_q    <= ID_W'(NUM_REQ - 1);
      tag_q        <= '0;
      fp_a_q       <= '0;
      fp_b_q       <= '0;
      fp_op_q      <= OP_ADD;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      op_count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fp_a_q    <= sel_a;
        fp_b_q    <= sel_b;
        fp_op_q   <= sel_op;
        tag_q     <= grant_id;
        last_id_q <= grant_id;
      end
      // The datapath has had the whole EXEC cycle to settle.
      if (state_q == ST_EXEC) begin
        rsp_result_q <= fp_result;
        rsp_id_q     <= tag_q;
        rsp_valid_q  <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
        op_count_q  <= op_count_q + 1'b1;
      end
    end
  end

  assign fp_a       = fp_a_q;
  assign fp_b       = fp_b_q;
  assign fp_op      = fp_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != ST_IDLE);
  assign op_count   = op_count_q;

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_rsp_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_result)));

  a_ready_idle_only : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != ST_IDLE) |-> (req_ready == '0));
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
module tb_fp_addsub_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a = '0;
  logic [NUM_REQ*WIDTH-1:0] req_b = '0;
  logic [NUM_REQ-1:0]       req_op = '0;
  logic [WIDTH-1:0]         fp_a, fp_b, fp_result;
  logic                     fp_op;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     busy;
  logic [CNT_W-1:0]         op_count;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Stand-in for the shared add_sub_main: exact for the normal values used here.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
    return r2sp(op ? (sp2r(a) - sp2r(b)) : (sp2r(a) + sp2r(b)));
  endfunction

  assign fp_result = fp_model(fp_a, fp_b, fp_op);

  fp_addsub_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .fp_a       (fp_a),
    .fp_b       (fp_b),
    .fp_op      (fp_op),
    .fp_result  (fp_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: one outstanding operation at a time. phase 0 means
  // nothing outstanding, 1 is the cycle after acceptance, 2+ is the response.
  // ---------------------------------------------------------------------------
  int          m_last = NUM_REQ - 1;
  int          m_phase = 0;
  int          m_count = 0;
  logic [31:0] m_fa = '0, m_fb = '0;
  logic        m_fop = 1'b0;
  int          m_id = 0;
  int          grant_log[$];
  int          accept_cyc[$];

  always @(negedge clk) begin : cmp
    logic [NUM_REQ-1:0] exp_ready;
    int pick;
    if (!rst_n) begin
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst fp_a", fp_a, 32'd0);
      check("rst op_count", 32'(op_count), 32'd0);
      m_last  = NUM_REQ - 1;
      m_phase = 0;
      m_count = 0;
      m_fa    = '0;
      m_fb    = '0;
      m_fop   = 1'b0;
    end else begin
      exp_ready = '0;
      pick = -1;
      if (m_phase == 0) begin
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
          if (pick < 0 && req_valid[(m_last + k) % NUM_REQ]) pick = (m_last + k) % NUM_REQ;
        end
        if (pick >= 0) exp_ready[pick] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_phase >= 2));
      check("fp_a", fp_a, m_fa);
      check("fp_b", fp_b, m_fb);
      check("fp_op", 32'(fp_op), 32'(m_fop));
      check("op_count", 32'(op_count), 32'(m_count));
      if (m_phase >= 2) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_result", rsp_result, fp_model(m_fa, m_fb, m_fop));
      end
      if (m_phase >= 2) begin
        if (rsp_ready) begin
          m_count = (m_count + 1) % (1 << CNT_W);
          m_phase = 0;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (pick >= 0) begin
        m_fa    = req_a[pick*WIDTH +: WIDTH];
        m_fb    = req_b[pick*WIDTH +: WIDTH];
        m_fop   = req_op[pick];
        m_id    = pick;
        m_last  = pick;
        m_phase = 1;
        grant_log.push_back(pick);
        accept_cyc.push_back(cycle);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i] = op;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Raise a request and hold it until accepted; returns the accept cycle.
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic op, output int c0);
    bit ok = 1'b0;
    c0 = 0;
    @(posedge clk);
    #1;
    set_req(i, a, b, op);
    req_valid[i] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        c0 = cycle;
        break;
      end
    end
    if (!ok) timeout("accept");
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [ID_W-1:0] id, output logic [31:0] res,
                          output int c2);
    bit ok = 1'b0;
    id = '0;
    res = '0;
    c2 = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        id = rsp_id;
        res = rsp_result;
        c2 = cycle;
        break;
      end
    end
    if (!ok) timeout("response");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("idle");
  endtask

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic op, output logic [ID_W-1:0] id,
                        output logic [31:0] res, output int lat);
    int c0, c2;
    send(i, a, b, op, c0);
    wait_rsp(id, res, c2);
    lat = c2 - c0;
    wait_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [ID_W-1:0] id;
    logic [31:0]     res;
    logic [31:0]     held_res;
    logic [ID_W-1:0] held_id;
    int              lat, c0, c2;
    bit              ok;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single add and single subtract.
    run_op(0, 32'h3F800000, 32'h40000000, 1'b0, id, res, lat);
    check("add id", 32'(id), 32'd0);
    check("add result", res, 32'h40400000);
    check("add latency", 32'(lat), 32'd2);
    check("add op_count", 32'(op_count), 32'd1);

    run_op(2, 32'h40A00000, 32'h3F800000, 1'b1, id, res, lat);
    check("sub id", 32'(id), 32'd2);
    check("sub result", res, 32'h40800000);
    check("sub op_count", 32'(op_count), 32'd2);

    // All requesters valid continuously after reset.
    do_reset();
    grant_log.delete();
    accept_cyc.delete();
    set_req(0, 32'h3F800000, 32'h3F000000, 1'b0);
    set_req(1, 32'h40000000, 32'h3F000000, 1'b1);
    set_req(2, 32'h40400000, 32'h3F000000, 1'b0);
    set_req(3, 32'h40800000, 32'h3F000000, 1'b1);
    req_valid = 4'b1111;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      #1;
      if (grant_log.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("round robin");
    @(posedge clk);
    #1;
    req_valid = '0;
    if (ok) begin
      check("rr grant0", 32'(grant_log[0]), 32'd0);
      check("rr grant1", 32'(grant_log[1]), 32'd1);
      check("rr grant2", 32'(grant_log[2]), 32'd2);
      check("rr grant3", 32'(grant_log[3]), 32'd3);
      check("rr grant4", 32'(grant_log[4]), 32'd0);
      for (int k = 1; k < 5; k++)
        check("rr interval", 32'(accept_cyc[k] - accept_cyc[k-1]), 32'd3);
    end
    wait_idle();

    // Backpressure while a response is pending.
    rsp_ready = 1'b0;
    send(1, 32'h40400000, 32'h3F800000, 1'b1, c0);
    wait_rsp(held_id, held_res, c2);
    check("bp id", 32'(held_id), 32'd1);
    check("bp result", held_res, 32'h40000000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        set_req(3, 32'h40000000, 32'h40000000, 1'b0);
        req_valid[3] = 1'b1;
      end
      @(negedge clk);
      check("bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp rsp_id", 32'(rsp_id), 32'(held_id));
      check("bp rsp_result", rsp_result, held_res);
      check("bp req_ready", 32'(req_ready), 32'd0);
      check("bp busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp release idle", 32'(busy), 32'd0);
    check("bp release ready", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(id, res, c2);
    check("bp next id", 32'(id), 32'd3);
    check("bp next result", res, 32'h40800000);
    wait_idle();

    // Reset while an operation is executing.
    send(1, 32'h40000000, 32'h3F800000, 1'b0, c0);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst fp_a", fp_a, 32'd0);
    check("midrst fp_b", fp_b, 32'd0);
    check("midrst op_count", 32'(op_count), 32'd0);
    check("midrst rsp_result", rsp_result, 32'd0);
    set_req(0, 32'h40000000, 32'h40000000, 1'b1);
    set_req(3, 32'h3F800000, 32'h3F800000, 1'b0);
    req_valid = 4'b1001;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset priority", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(id, res, c2);
    check("post-reset id", 32'(id), 32'd0);
    check("post-reset result", res, 32'h00000000);
    wait_idle();

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int n = 1; n <= 17; n++) begin
      run_op(n % 4, 32'h3F800000, 32'h40000000, n[0], id, res, lat);
      if (n == 15) check("wrap 15", 32'(op_count), 32'd15);
      if (n == 16) check("wrap 0", 32'(op_count), 32'd0);
      if (n == 17) check("wrap 1", 32'(op_count), 32'd1);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

endmodule
